// File: rtl/pipe_step_ctrl.sv
// Debug execution controller for the 5-stage pipeline: free-run, pause, single-step
// and permanent halt on the HALT instruction reaching MEM/WB.
module pipe_step_ctrl #(
    parameter int CYCLE_W  = 32,
    parameter int STEP_LEN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic               i_stop_wb,
    output logic               o_step,
    output logic [1:0]         o_state,
    output logic [CYCLE_W-1:0] o_cycle_count,
    output logic               o_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_PAUSE = 2'b11;

    localparam logic [7:0]         STEP_LOAD = 8'(STEP_LEN - 1);
    localparam logic [CYCLE_W-1:0] CNT_ONE   = {{(CYCLE_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [7:0]         step_cnt;
    logic [CYCLE_W-1:0] cycle_count;
    logic               done;
    logic               cmd_fire;
    logic               halt_now;

    // Enable and ready depend on the state register only, so no input reaches an output.
    assign o_step      = (state == S_RUN) || (state == S_STEP);
    assign o_cmd_ready = (state == S_IDLE) || (state == S_RUN);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    // stop_pipe is only meaningful while the latches are actually advancing.
    assign halt_now    = o_step && i_stop_wb;

    assign o_state       = state;
    assign o_cycle_count = cycle_count;
    assign o_done        = done;

    // NOTE: every register here is updated with <= so all next-state terms read the
    // pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            step_cnt    <= 8'd0;
            cycle_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (o_step && (cycle_count != {CYCLE_W{1'b1}}))
                cycle_count <= cycle_count + CNT_ONE;

            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (i_cmd)
                            CMD_RUN:  state <= S_RUN;
                            CMD_STEP: begin
                                state    <= S_STEP;
                                step_cnt <= STEP_LOAD;
                            end
                            default:  state <= S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    if (halt_now) begin
                        state <= S_HALTED;
                        done  <= 1'b1;
                    end else if (cmd_fire && (i_cmd == CMD_PAUSE)) begin
                        state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (halt_now) begin
                        state <= S_HALTED;
                        done  <= 1'b1;
                    end else if (step_cnt == 8'd0) begin
                        state <= S_IDLE;
                    end else begin
                        step_cnt <= step_cnt - 8'd1;
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end

endmodule
